// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard definitions: frame FSM state encoding, scan-code constants
// used by the receiver and the player-movement logic, and the frame parity helper.
package ps2_pkg;

   typedef logic [1:0] ps2_state_t;

   localparam ps2_state_t IDLE   = 2'd0;
   localparam ps2_state_t DATA   = 2'd1;
   localparam ps2_state_t PARITY = 2'd2;
   localparam ps2_state_t STOP   = 2'd3;

   localparam logic [7:0] BREAK_CODE = 8'hF0;
   localparam logic [7:0] EXT_CODE   = 8'hE0;
   localparam logic [7:0] KEY_LEFT   = 8'h6B;
   localparam logic [7:0] KEY_RIGHT  = 8'h74;

   // PS/2 frames carry odd parity over the data byte plus the parity bit
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
      return ^{data, parity};
   endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the PS/2 clock and data lines plus a falling-edge
// detector on the synchronized clock. Flops reset to 1 to match an idle bus.
module ps2_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic data_s,
   output logic fall_s
);

   logic clk_meta_r;
   logic clk_sync_r;
   logic clk_prev_r;
   logic data_meta_r;
   logic data_sync_r;

   // Synchronizer chains and previous-cycle copy of the synchronized clock
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_meta_r  <= 1'b1;
         clk_sync_r  <= 1'b1;
         clk_prev_r  <= 1'b1;
         data_meta_r <= 1'b1;
         data_sync_r <= 1'b1;
      end else begin
         clk_meta_r  <= ps2_clk;
         clk_sync_r  <= clk_meta_r;
         clk_prev_r  <= clk_sync_r;
         data_meta_r <= ps2_data;
         data_sync_r <= data_meta_r;
      end
   end

   assign data_s = data_sync_r;
   assign fall_s = clk_prev_r & ~clk_sync_r;

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: deframes 11-bit frames and tracks the currently held
// make code, handling the E0 extended prefix and F0 break prefix.
module ps2_scan_rx
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] scan_code,
   output logic       extended,
   output logic       code_valid,
   output logic       frame_error
);

   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic             data_s;
   logic             fall_s;
   ps2_state_t       state_r;
   logic [2:0]       bit_cnt_r;
   logic [7:0]       shift_r;
   logic             parity_r;
   logic [TMO_W-1:0] tmo_cnt_r;
   logic             brk_pend_r;
   logic             ext_pend_r;

   logic             start_err_s;
   logic             byte_good_s;
   logic             byte_bad_s;
   logic             timeout_s;

   ps2_sync_edge u_sync (
      .clk      (clk),
      .reset    (reset),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .data_s   (data_s),
      .fall_s   (fall_s)
   );

   // Frame-level events derived from the current state and the edge strobe
   always_comb begin
      start_err_s = 1'b0;
      byte_good_s = 1'b0;
      byte_bad_s  = 1'b0;
      timeout_s   = 1'b0;
      if (fall_s) begin
         if (state_r == IDLE) begin
            start_err_s = data_s;
         end else if (state_r == STOP) begin
            byte_good_s = data_s & odd_parity_ok(shift_r, parity_r);
            byte_bad_s  = ~byte_good_s;
         end else begin
            start_err_s = 1'b0;
         end
      end else begin
         timeout_s = (state_r != IDLE) && (tmo_cnt_r == TMO_LAST);
      end
   end

   // Frame FSM: advances only on PS/2 falling edges, aborted by timeout
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         bit_cnt_r <= 3'd0;
         shift_r   <= 8'h00;
         parity_r  <= 1'b0;
      end else if (timeout_s) begin
         state_r   <= IDLE;
         bit_cnt_r <= 3'd0;
         shift_r   <= 8'h00;
         parity_r  <= 1'b0;
      end else if (fall_s) begin
         case (state_r)
            IDLE: begin
               bit_cnt_r <= 3'd0;
               state_r   <= data_s ? IDLE : DATA;
            end
            DATA: begin
               shift_r   <= {data_s, shift_r[7:1]};
               bit_cnt_r <= bit_cnt_r + 3'd1;
               if (bit_cnt_r == 3'd7) begin
                  state_r <= PARITY;
               end
            end
            PARITY: begin
               parity_r <= data_s;
               state_r  <= STOP;
            end
            STOP: begin
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Inactivity counter, cleared by every edge and whenever the bus is idle
   always_ff @(posedge clk) begin
      if (reset || fall_s || timeout_s || (state_r == IDLE)) begin
         tmo_cnt_r <= {TMO_W{1'b0}};
      end else begin
         tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
      end
   end

   // Byte decoder: prefix flags, held-key tracking and event pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         scan_code   <= 8'h00;
         extended    <= 1'b0;
         code_valid  <= 1'b0;
         frame_error <= 1'b0;
         brk_pend_r  <= 1'b0;
         ext_pend_r  <= 1'b0;
      end else begin
         code_valid  <= 1'b0;
         frame_error <= start_err_s | byte_bad_s | timeout_s;
         if (byte_good_s) begin
            if (shift_r == BREAK_CODE) begin
               brk_pend_r <= 1'b1;
            end else if (shift_r == EXT_CODE) begin
               ext_pend_r <= 1'b1;
            end else if (brk_pend_r) begin
               // Releasing a key other than the held one leaves the held key in place
               if (shift_r == scan_code) begin
                  scan_code <= 8'h00;
                  extended  <= 1'b0;
               end
               brk_pend_r <= 1'b0;
               ext_pend_r <= 1'b0;
            end else begin
               scan_code  <= shift_r;
               extended   <= ext_pend_r;
               code_valid <= 1'b1;
               ext_pend_r <= 1'b0;
            end
         end else if (byte_bad_s) begin
            brk_pend_r <= 1'b0;
            ext_pend_r <= 1'b0;
         end
      end
   end

endmodule
